// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multiport register file and its clear sequencer.
package regfile_pkg;

  typedef enum logic {IDLE, CLEARING} clearState_t;

  localparam int unsigned BYTE     = 8;
  // Widest word mergeBytes handles; callers extend to this width and truncate the result.
  localparam int unsigned MaxWidth = 256;

  function automatic logic [MaxWidth-1:0] mergeBytes(
    input logic [MaxWidth-1:0]      oldWord,
    input logic [MaxWidth-1:0]      newWord,
    input logic [MaxWidth/BYTE-1:0] mask
  );
    logic [MaxWidth-1:0] merged;
    merged = oldWord;
    for (int unsigned i = 0; i < MaxWidth/BYTE; i++) begin
      if (mask[i]) merged[i*BYTE +: BYTE] = newWord[i*BYTE +: BYTE];
    end
    return merged;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Bulk-clear sequencer: walks the register array one row per cycle after a Clear request.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned Depth     = 64,
  parameter int unsigned AddrWidth = $clog2(Depth)
) (
  input  logic                 Clock,
  input  logic                 nReset,
  input  logic                 Clear,
  output logic                 Busy,
  output logic [AddrWidth-1:0] ClearRow,
  output logic                 ClearActive
);

  clearState_t          state, stateNext;
  logic [AddrWidth-1:0] rowCount, rowCountNext;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      rowCount <= '0;
      Busy     <= 1'b0;
    end else begin
      state    <= stateNext;
      rowCount <= rowCountNext;
      Busy     <= (stateNext == CLEARING);
    end
  end

  always_comb begin
    stateNext    = state;
    rowCountNext = rowCount;
    unique case (state)
      IDLE: begin
        if (Clear) begin
          stateNext    = CLEARING;
          rowCountNext = '0;
        end
      end
      CLEARING: begin
        // Counter wraps to 0 on the last row, leaving it ready for the next sequence.
        rowCountNext = rowCount + AddrWidth'(1);
        if (rowCount == AddrWidth'(Depth - 1)) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign ClearRow    = rowCount;
  assign ClearActive = (state == CLEARING);

endmodule

// File: rtl/multiport_register_file.sv
// Register file with N registered write-first read ports, one byte-masked write port
// and a sequenced bulk clear.
module multiport_register_file
  import regfile_pkg::*;
#(
  parameter int unsigned DataWidth    = 16,
  parameter int unsigned Depth        = 64,
  parameter int unsigned ReadPorts    = 2,
  parameter int unsigned ZeroRegister = 0,
  parameter int unsigned AddrWidth    = $clog2(Depth)
) (
  input  logic                      Clock,
  input  logic                      nReset,
  input  logic                      WriteEnable,
  input  logic [AddrWidth-1:0]      WriteAddress,
  input  logic [DataWidth-1:0]      WriteData,
  input  logic [DataWidth/BYTE-1:0] WriteMask,
  input  logic [AddrWidth-1:0]      ReadAddress [ReadPorts],
  output logic [DataWidth-1:0]      ReadData    [ReadPorts],
  input  logic                      Clear,
  output logic                      Busy
);

  logic [DataWidth-1:0] regs [Depth];
  logic [AddrWidth-1:0] clearRow;
  logic                 clearActive;
  logic                 writeAccept;
  logic [DataWidth-1:0] mergedWord;

  regfile_clear_seq #(
    .Depth     (Depth),
    .AddrWidth (AddrWidth)
  ) uClearSeq (
    .Clock       (Clock),
    .nReset      (nReset),
    .Clear       (Clear),
    .Busy        (Busy),
    .ClearRow    (clearRow),
    .ClearActive (clearActive)
  );

  assign writeAccept = WriteEnable && !clearActive &&
                       !((ZeroRegister != 0) && (WriteAddress == '0));
  assign mergedWord  = DataWidth'(mergeBytes(MaxWidth'(regs[WriteAddress]),
                                             MaxWidth'(WriteData),
                                             (MaxWidth/BYTE)'(WriteMask)));

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int unsigned r = 0; r < Depth; r++) regs[r] <= '0;
    end else if (clearActive) begin
      regs[clearRow] <= '0;
    end else if (writeAccept) begin
      regs[WriteAddress] <= mergedWord;
    end
  end

  for (genvar p = 0; p < ReadPorts; p++) begin : gRead
    logic [DataWidth-1:0] readReg;

    // Priority mirrors the array update so each port sees post-edge contents.
    always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
        readReg <= '0;
      end else if ((ZeroRegister != 0) && (ReadAddress[p] == '0)) begin
        readReg <= '0;
      end else if (clearActive && (ReadAddress[p] == clearRow)) begin
        readReg <= '0;
      end else if (writeAccept && (ReadAddress[p] == WriteAddress)) begin
        readReg <= mergedWord;
      end else begin
        readReg <= regs[ReadAddress[p]];
      end
    end

    assign ReadData[p] = readReg;
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Scoreboard bench: a reference model predicts post-edge contents for two instances
// (ZeroRegister off and on) sharing the same stimulus.
module tb_multiport_register_file;

  localparam int unsigned DataWidth = 16;
  localparam int unsigned Depth     = 64;
  localparam int unsigned ReadPorts = 2;
  localparam int unsigned AddrWidth = 6;

  logic                 Clock = 1'b0;
  logic                 nReset = 1'b0;
  logic                 WriteEnable = 1'b0;
  logic [AddrWidth-1:0] WriteAddress = '0;
  logic [DataWidth-1:0] WriteData = '0;
  logic [1:0]           WriteMask = '0;
  logic                 Clear = 1'b0;
  logic [AddrWidth-1:0] ReadAddress [ReadPorts];
  logic [DataWidth-1:0] readData0 [ReadPorts];
  logic [DataWidth-1:0] readData1 [ReadPorts];
  logic                 busy0, busy1;

  multiport_register_file #(
    .DataWidth (DataWidth), .Depth (Depth), .ReadPorts (ReadPorts), .ZeroRegister (0)
  ) dut0 (
    .Clock (Clock), .nReset (nReset), .WriteEnable (WriteEnable),
    .WriteAddress (WriteAddress), .WriteData (WriteData), .WriteMask (WriteMask),
    .ReadAddress (ReadAddress), .ReadData (readData0), .Clear (Clear), .Busy (busy0)
  );

  multiport_register_file #(
    .DataWidth (DataWidth), .Depth (Depth), .ReadPorts (ReadPorts), .ZeroRegister (1)
  ) dut1 (
    .Clock (Clock), .nReset (nReset), .WriteEnable (WriteEnable),
    .WriteAddress (WriteAddress), .WriteData (WriteData), .WriteMask (WriteMask),
    .ReadAddress (ReadAddress), .ReadData (readData1), .Clear (Clear), .Busy (busy1)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string          tag;
    int             dutSel;
    int             port;
    logic [15:0]    expVal;
  } expect_t;

  expect_t     sbQueue [$];
  logic [15:0] modelMem [2][Depth];
  bit          modelBusy;
  int unsigned modelRow;
  int          checks = 0;
  int          errors = 0;

  task automatic checkValue(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  function automatic logic [15:0] dutValue(input int dutSel, input int port);
    if (port < 0) return (dutSel == 0) ? {15'b0, busy0} : {15'b0, busy1};
    return (dutSel == 0) ? readData0[port] : readData1[port];
  endfunction

  task automatic setWrite(input bit en, input int addr, input logic [15:0] data, input logic [1:0] mask);
    WriteEnable  = en;
    WriteAddress = AddrWidth'(addr);
    WriteData    = data;
    WriteMask    = mask;
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < Depth; r++) modelMem[d][r] = '0;
    modelBusy = 1'b0;
    modelRow  = 0;
  endtask

  // Checks the asynchronous reset state without waiting for a clock edge.
  task automatic checkResetState(input string tag);
    for (int d = 0; d < 2; d++) begin
      checkValue($sformatf("%s busy d%0d", tag, d), dutValue(d, -1), 16'h0000);
      for (int p = 0; p < ReadPorts; p++)
        checkValue($sformatf("%s rd d%0d p%0d", tag, d, p), dutValue(d, p), 16'h0000);
    end
  endtask

  // Advance the model through the coming edge, queue predictions, clock, then compare.
  task automatic step(input string tag);
    expect_t e;
    for (int d = 0; d < 2; d++) begin
      if (modelBusy) modelMem[d][modelRow] = '0;
      else if (WriteEnable && !(d == 1 && WriteAddress == 0))
        for (int b = 0; b < 2; b++)
          if (WriteMask[b]) modelMem[d][WriteAddress][8*b +: 8] = WriteData[8*b +: 8];
    end
    if (modelBusy) begin
      if (modelRow == Depth - 1) modelBusy = 1'b0;
      modelRow = (modelRow + 1) % Depth;
    end else if (Clear) begin
      modelBusy = 1'b1;
      modelRow  = 0;
    end
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < ReadPorts; p++) begin
        e.tag    = $sformatf("%s rd d%0d p%0d a%0d", tag, d, p, ReadAddress[p]);
        e.dutSel = d;
        e.port   = p;
        e.expVal = (d == 1 && ReadAddress[p] == 0) ? 16'h0000 : modelMem[d][ReadAddress[p]];
        sbQueue.push_back(e);
      end
      e.tag    = $sformatf("%s busy d%0d", tag, d);
      e.dutSel = d;
      e.port   = -1;
      e.expVal = {15'b0, modelBusy};
      sbQueue.push_back(e);
    end
    @(posedge Clock);
    #1;
    while (sbQueue.size() > 0) begin
      e = sbQueue.pop_front();
      checkValue(e.tag, dutValue(e.dutSel, e.port), e.expVal);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busyCycles;
    int guard;

    ReadAddress[0] = '0;
    ReadAddress[1] = '0;
    modelReset();
    #12;
    checkResetState("reset");
    @(negedge Clock);
    nReset = 1'b1;

    // Reset contents read as zero.
    ReadAddress[0] = 6'd10;
    ReadAddress[1] = 6'd63;
    step("post_reset");

    // Basic write, then read next cycle.
    setWrite(1, 1, 16'h02AD, 2'b11);
    ReadAddress[0] = 6'd5;
    step("write1");
    setWrite(0, 0, 16'h0000, 2'b00);
    ReadAddress[0] = 6'd1;
    step("read1");

    // Byte masking on address 7, including an all-zero mask.
    ReadAddress[0] = 6'd7;
    setWrite(1, 7, 16'hADAD, 2'b11);
    step("mask_full");
    setWrite(1, 7, 16'h1234, 2'b01);
    step("mask_lo");
    setWrite(1, 7, 16'h5600, 2'b10);
    step("mask_hi");
    setWrite(1, 7, 16'hFFFF, 2'b00);
    step("mask_none");

    // Write-first bypass seen by both ports at once.
    ReadAddress[0] = 6'd13;
    ReadAddress[1] = 6'd13;
    setWrite(1, 13, 16'h0001, 2'b11);
    step("bypass");

    // Address 0 is writable only without ZeroRegister; address 1 normal in both.
    ReadAddress[0] = 6'd0;
    ReadAddress[1] = 6'd0;
    setWrite(1, 0, 16'hFFFF, 2'b11);
    step("zero_wr");
    setWrite(0, 0, 16'h0000, 2'b00);
    step("zero_rd");
    ReadAddress[1] = 6'd1;
    setWrite(1, 1, 16'hBEEF, 2'b11);
    step("zero_addr1");

    // Fill the array, then clear with a simultaneous write to row 63.
    for (int r = 0; r < Depth; r++) begin
      ReadAddress[0] = AddrWidth'(r);
      setWrite(1, r, 16'hA5A5, 2'b11);
      step("fill");
    end
    ReadAddress[0] = 6'd63;
    ReadAddress[1] = 6'd5;
    setWrite(1, 63, 16'h7777, 2'b11);
    Clear = 1'b1;
    step("clear_start");
    Clear = 1'b0;

    busyCycles = 0;
    guard      = 0;
    while (busy0 && guard < 200) begin
      busyCycles++;
      guard++;
      Clear = (busyCycles == 10);
      if (busyCycles == 30) begin
        setWrite(1, 5, 16'h1111, 2'b11);
        ReadAddress[0] = 6'd5;
      end else begin
        setWrite(1, 60, 16'h3333, 2'b11);
      end
      ReadAddress[1] = AddrWidth'(modelRow);
      step("clearing");
    end
    Clear = 1'b0;
    checkValue("busy_cycles", 16'(busyCycles), 16'd64);

    // Write still presented right after Busy falls is the first one accepted.
    ReadAddress[1] = 6'd60;
    step("first_write");
    setWrite(0, 0, 16'h0000, 2'b00);
    for (int r = 0; r < Depth; r += 2) begin
      ReadAddress[0] = AddrWidth'(r);
      ReadAddress[1] = AddrWidth'(r + 1);
      step("after_clear");
    end

    // Reset while the clear sequence is at row 20.
    setWrite(1, 30, 16'hCAFE, 2'b11);
    ReadAddress[0] = 6'd30;
    step("pre_abort");
    setWrite(0, 0, 16'h0000, 2'b00);
    Clear = 1'b1;
    step("abort_start");
    Clear = 1'b0;
    guard = 0;
    while (modelRow != 20 && guard < 100) begin
      guard++;
      step("abort_run");
    end
    @(negedge Clock);
    nReset = 1'b0;
    modelReset();
    #1;
    checkResetState("abort_reset");
    @(negedge Clock);
    nReset = 1'b1;
    ReadAddress[0] = 6'd2;
    ReadAddress[1] = 6'd30;
    setWrite(1, 2, 16'h4242, 2'b11);
    step("post_abort_write");
    setWrite(0, 0, 16'h0000, 2'b00);
    step("post_abort_read");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
